registerfile_param: RTL
=======================

# registerfile_param

Parametrised multi-port register file for the pipeline's decode/writeback stages, generalising the fixed 4×16-bit, 3-read/2-write file. It adds configurable width, depth and port counts, deterministic write-port priority, optional same-cycle write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard that decode uses to detect RAW hazards on in-flight writes.

## Interface
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 8, number of registers; power of two, ≥2; AW = clog2(DEPTH) derived internally
- NUM_RD, 3, read ports (≥1)
- NUM_WR, 2, write ports (≥1)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
- ZERO_REG, 0, 1 = register 0 reads 0, ignores writes, never busy
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
- rd_busy  out  NUM_RD  busy (pending write) flag of addressed register
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*WIDTH  write data
- wr_enable  in  NUM_WR  per-port write strobe
- rsv_addr  in  AW  destination register being issued
- rsv_enable  in  1  mark rsv_addr busy
- wr_conflict  out  1  registered; 1 for one cycle after ≥2 enabled write ports targeted the same address

## Operation
- Storage: DEPTH × WIDTH data array plus DEPTH-bit busy vector.
- Write: on rising clock, each port with wr_enable=1 writes wr_data to wr_addr.
- Port priority: if several enabled ports share an address, highest-index port's data is stored; others dropped for that address; wr_conflict asserted next cycle.
- Read (combinational): rd_data[i] = data[rd_addr[i]].
- Bypass (BYPASS=1): if any enabled write port matches rd_addr[i] this cycle, rd_data[i] = winning (highest-index) port's wr_data and rd_busy[i] = 0.
- Scoreboard: rsv_enable=1 sets busy[rsv_addr] at clock edge; an enabled write clears busy[wr_addr] at clock edge.
- Set/clear same address same edge: set wins (busy stays 1; newer reservation outstanding).
- rd_busy[i] = busy[rd_addr[i]] (subject to bypass override above).
- ZERO_REG=1: writes to address 0 ignored (also excluded from conflict detection and bypass); rd_data for address 0 is 0; rsv to address 0 ignored; rd_busy for address 0 is 0.
- Multiple reads of the same address on different ports are legal and return identical values.

## Timing
- reset asserted: all data = 0, busy = 0, wr_conflict = 0 immediately (asynchronous); rd_data = 0 and rd_busy = 0 on all ports absent bypass.
- Reset mid-operation overrides same-cycle writes and reservations; nothing is retained.
- Write latency: stored on edge N, visible via array on cycle N+1; visible same cycle N via bypass when BYPASS=1.
- Scoreboard latency: rsv on edge N → rd_busy=1 from cycle N+1 until the cycle after the clearing write's edge (or during it with BYPASS=1).
- wr_conflict: registered, high exactly for cycle N+1 after conflicting cycle N; cleared by reset.
- Out-of-range addresses cannot occur (DEPTH power of two).

## Test plan
- Reset: write 0xBEEF to all regs, pulse reset mid-cycle → all rd_data = 0x0000, rd_busy = 0, wr_conflict = 0 immediately.
- Basic R/W: port0 writes 0x1234 to r3, port1 writes 0xABCD to r5 same edge → next cycle rd_addr=3,5,3 gives 0x1234, 0xABCD, 0x1234.
- Conflict: port0 writes 0x1111, port1 writes 0x2222 to r2 same cycle → r2 = 0x2222; wr_conflict = 1 for exactly one cycle then 0.
- Bypass: BYPASS=1, read r4 while port0 writes 0x5A5A to r4 → rd_data = 0x5A5A same cycle; rerun with BYPASS=0 → old value that cycle, 0x5A5A next.
- Scoreboard: rsv r6 at edge N → rd_busy=1 from N+1; write r6 at edge M → rd_busy=0 from M+1; rsv and write r6 same edge → stays busy.
- ZERO_REG=1: write 0xFFFF to r0, rsv r0 → rd_data = 0, rd_busy = 0, wr_conflict never set by r0 collisions.

Source files
------------

// File: rtl/registerfile_param.sv
// registerfile_param: a parametrised multi-port register file with a RAW-hazard scoreboard.
// Write ports are resolved by priority: when several enabled ports name the same
// register, the port with the highest index wins. Same-cycle write data can optionally
// be forwarded to the read ports. Register 0 can optionally be hardwired to zero.
// The file also keeps one busy bit per register. Decode sets a busy bit when it issues
// an instruction to that destination, and writeback clears it when the result arrives.
module registerfile_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic [NUM_WR*AW-1:0]    wr_addr,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [NUM_WR-1:0]       wr_enable,
  input  logic [AW-1:0]           rsv_addr,
  input  logic                    rsv_enable,
  output logic                    wr_conflict
);

  localparam logic [AW-1:0] ADDR_ZERO = '0;

  // Storage and scoreboard state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_q;

  // Unpacked views of the flat port buses
  logic [AW-1:0]    rd_addr_a [NUM_RD];
  logic [AW-1:0]    wr_addr_a [NUM_WR];
  logic [WIDTH-1:0] wr_data_a [NUM_WR];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign rd_addr_a[i] = rd_addr[i*AW +: AW];
  end

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_unpack
    assign wr_addr_a[p] = wr_addr[p*AW +: AW];
    assign wr_data_a[p] = wr_data[p*WIDTH +: WIDTH];
  end

  // Per-register write decode results
  logic [NUM_WR-1:0] wr_eff;        // port enabled and not aimed at a hardwired zero register
  logic [DEPTH-1:0]  wr_hit;        // register is written at the coming edge
  logic [WIDTH-1:0]  wr_win [DEPTH]; // data from the winning (highest-index) port
  logic              conflict;      // two or more effective ports share an address
  logic              rsv_eff;       // reservation that actually takes effect
  logic [DEPTH-1:0]  busy_next;

  // Qualify each write port. When the zero register is enabled, writes to r0 do not exist.
  always_comb begin
    // NOTE: Every variable assigned in an always_comb block gets a default value first.
    // This way no path through the block leaves it unassigned, and no latch is inferred.
    wr_eff = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_eff[p] = wr_enable[p] && !(ZERO_REG != 0 && wr_addr_a[p] == ADDR_ZERO);
    end
  end

  // Resolve the winning write data for each register.
  // Ports are scanned in ascending order, so the highest enabled port lands last and wins.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wr_win[r] = '0;
    end
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_eff[p]) begin
        // NOTE: Blocking assignments are used in combinational logic.
        // A later port overwrites an earlier port within this same evaluation, which is
        // how priority is expressed. Sequential state uses non-blocking assignments only.
        wr_hit[wr_addr_a[p]] = 1'b1;
        wr_win[wr_addr_a[p]] = wr_data_a[p];
      end
    end
  end

  // Detect two or more effective write ports targeting the same register.
  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (wr_eff[p] && wr_eff[q] && wr_addr_a[p] == wr_addr_a[q]) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Compute the next busy vector.
  // Writes clear their busy bits first, then a reservation sets its bit. If both hit the
  // same register, the newer reservation is still outstanding, so the register stays busy.
  always_comb begin
    rsv_eff   = rsv_enable && !(ZERO_REG != 0 && rsv_addr == ADDR_ZERO);
    busy_next = busy_q & ~wr_hit;
    if (rsv_eff) begin
      busy_next[rsv_addr] = 1'b1;
    end
  end

  // Update the data array, the scoreboard and the conflict flag. All are cleared by the
  // asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: The data array is reset on purpose. After reset, every register must read as
      // zero, so this array is built from flops rather than an inferred RAM macro.
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
      busy_q      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit[r]) begin
          mem[r] <= wr_win[r];
        end
      end
      busy_q      <= busy_next;
      wr_conflict <= conflict;
    end
  end

  // Combinational read ports. Each port shows one of three things, in this order:
  // the hardwired zero register; same-cycle write data (when BYPASS is set); or the stored
  // value and busy bit.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ZERO_REG != 0 && rd_addr_a[i] == ADDR_ZERO) begin
        rd_data[i*WIDTH +: WIDTH] = '0;
        rd_busy[i]                = 1'b0;
      end else if (BYPASS != 0 && wr_hit[rd_addr_a[i]]) begin
        rd_data[i*WIDTH +: WIDTH] = wr_win[rd_addr_a[i]];
        rd_busy[i]                = 1'b0;
      end else begin
        rd_data[i*WIDTH +: WIDTH] = mem[rd_addr_a[i]];
        rd_busy[i]                = busy_q[rd_addr_a[i]];
      end
    end
  end

endmodule
